// File: rtl/spi_master_queue.sv
// spi_master_queue
//   Byte queue and sequencer that sits directly upstream of an SPI master.
//   The host writes TX words over a valid/ready stream into a TX FIFO. A small
//   FSM issues each word to the master with a one-cycle send pulse and waits
//   for the arrived pulse. It then pushes the received word into an RX FIFO,
//   which the host drains over a second valid/ready stream.
//
// Ports
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   in_valid     host TX word valid
//   in_ready     TX FIFO can accept (not full)
//   in_data      host TX word
//   out_valid    RX FIFO non-empty
//   out_ready    host pops RX head
//   out_data     RX FIFO head (don't-care when out_valid=0)
//   spi_ready    master idle
//   spi_send     registered one-cycle start pulse to the master
//   spi_data     registered word to transmit
//   spi_arrived  one-cycle pulse, received word valid
//   spi_dataO    received word
//   tx_count     TX FIFO occupancy, 0..DEPTH
//   rx_count     RX FIFO occupancy, 0..DEPTH
//   busy         FSM not in IDLE
//   overrun      sticky: a word arrived outside WAIT and was discarded
module spi_master_queue #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           out_data,
  input  logic                       spi_ready,
  output logic                       spi_send,
  output logic [WIDTH-1:0]           spi_data,
  input  logic                       spi_arrived,
  input  logic [WIDTH-1:0]           spi_dataO,
  output logic [$clog2(DEPTH):0]     tx_count,
  output logic [$clog2(DEPTH):0]     rx_count,
  output logic                       busy,
  output logic                       overrun
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  state_t           state;

  logic [WIDTH-1:0] tx_mem [DEPTH];
  logic [AW-1:0]    tx_wp, tx_rp;
  logic [WIDTH-1:0] rx_mem [DEPTH];
  logic [AW-1:0]    rx_wp, rx_rp;

  logic tx_push, tx_pop, rx_push, rx_pop, start;

  assign in_ready  = (tx_count != FULL);
  assign out_valid = (rx_count != '0);
  assign out_data  = rx_mem[rx_rp];

  // Requiring a free RX slot before issuing guarantees the reply always fits.
  assign start   = (tx_count != '0) && (rx_count != FULL) && spi_ready;
  assign tx_push = in_valid & in_ready;
  assign tx_pop  = (state == IDLE) && start;
  assign rx_push = (state == WAIT) && spi_arrived;
  assign rx_pop  = out_valid & out_ready;

  // TX FIFO control
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_wp    <= '0;
      tx_rp    <= '0;
      tx_count <= '0;
    end else begin
      if (tx_push) tx_wp <= tx_wp + AW'(1);
      if (tx_pop)  tx_rp <= tx_rp + AW'(1);
      case ({tx_push, tx_pop})
        2'b10:   tx_count <= tx_count + (AW+1)'(1);
        2'b01:   tx_count <= tx_count - (AW+1)'(1);
        default: tx_count <= tx_count;
      endcase
    end
  end

  // Storage is not reset: contents are only meaningful behind the counts.
  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wp] <= in_data;
  end

  // RX FIFO control
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_wp    <= '0;
      rx_rp    <= '0;
      rx_count <= '0;
    end else begin
      if (rx_push) rx_wp <= rx_wp + AW'(1);
      if (rx_pop)  rx_rp <= rx_rp + AW'(1);
      case ({rx_push, rx_pop})
        2'b10:   rx_count <= rx_count + (AW+1)'(1);
        2'b01:   rx_count <= rx_count - (AW+1)'(1);
        default: rx_count <= rx_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rx_push) rx_mem[rx_wp] <= spi_dataO;
  end

  // Sequencer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      spi_send <= 1'b0;
      spi_data <= '0;
      busy     <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      spi_send <= 1'b0;
      // A word arriving while nothing is outstanding cannot be matched to a
      // request; it is dropped and flagged.
      if (spi_arrived && (state != WAIT)) overrun <= 1'b1;
      case (state)
        IDLE: begin
          if (start) begin
            state    <= ISSUE;
            spi_send <= 1'b1;
            spi_data <= tx_mem[tx_rp];
            busy     <= 1'b1;
          end
        end
        ISSUE: state <= WAIT;
        WAIT: begin
          if (spi_arrived) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_master_queue.sv
module tb_spi_master_queue;

  localparam int WIDTH = 8;
  localparam int DEPTH = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid, in_ready, out_valid, out_ready;
  logic [WIDTH-1:0] in_data, out_data, spi_data, spi_dataO;
  logic             spi_ready, spi_send, spi_arrived, busy, overrun;
  logic [2:0]       tx_count, rx_count;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  spi_master_queue #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .spi_ready(spi_ready), .spi_send(spi_send), .spi_data(spi_data),
    .spi_arrived(spi_arrived), .spi_dataO(spi_dataO),
    .tx_count(tx_count), .rx_count(rx_count), .busy(busy), .overrun(overrun)
  );

  typedef struct {
    logic       iv;
    logic [7:0] id;
    logic       sr;
    logic       arr;
    logic [7:0] ado;
    logic       ordy;
    logic       e_send;
    logic [7:0] e_sdata;
    logic [2:0] e_tx;
    logic [2:0] e_rx;
    logic       e_ovld;
    logic [7:0] e_od;
    logic       e_busy;
    logic       e_ir;
  } vec_t;

  vec_t vt [13];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Behaves like the master: waits for a send, checks its word, answers with
  // the inverted word a few cycles later.
  task automatic serve(input logic [7:0] exp);
    int t;
    t = 0;
    while (spi_send !== 1'b1 && t < 40) begin
      step();
      t++;
    end
    chk("serve_send_seen", spi_send, 1);
    chk("serve_data", spi_data, exp);
    step();
    chk("send_one_cycle", spi_send, 0);
    step();
    step();
    spi_arrived = 1'b1;
    spi_dataO   = ~spi_data;
    step();
    spi_arrived = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [7:0] exp_rx [4];
    int tx_m, rx_m, ms, ntx, nrx, nsent, wcnt, cyc;
    logic push, issue, rxpush, rxpop;

    // Vector table: inputs for one cycle, then outputs after the edge.
    vt[0]  = '{1, 8'hA5, 1, 0, 8'h00, 0,  0, 8'h00, 3'd1, 3'd0, 0, 8'h00, 0, 1};
    vt[1]  = '{0, 8'h00, 1, 0, 8'h00, 0,  1, 8'hA5, 3'd0, 3'd0, 0, 8'h00, 1, 1};
    for (int i = 2; i <= 10; i++)
      vt[i] = '{0, 8'h00, 1, 0, 8'h00, 0,  0, 8'hA5, 3'd0, 3'd0, 0, 8'h00, 1, 1};
    vt[11] = '{0, 8'h00, 1, 1, 8'h3C, 0,  0, 8'hA5, 3'd0, 3'd1, 1, 8'h3C, 0, 1};
    vt[12] = '{0, 8'h00, 1, 0, 8'h00, 1,  0, 8'hA5, 3'd0, 3'd0, 0, 8'h00, 0, 1};

    rst_n = 1'b0; in_valid = 0; in_data = 0; out_ready = 0;
    spi_ready = 0; spi_arrived = 0; spi_dataO = 0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_spi_send", spi_send, 0);
    chk("rst_spi_data", spi_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_tx_count", tx_count, 0);
    chk("rst_rx_count", rx_count, 0);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // Single word A5, reply 3C
    for (int i = 0; i < 13; i++) begin
      in_valid = vt[i].iv; in_data = vt[i].id; spi_ready = vt[i].sr;
      spi_arrived = vt[i].arr; spi_dataO = vt[i].ado; out_ready = vt[i].ordy;
      step();
      chk($sformatf("v%0d_send", i), spi_send, vt[i].e_send);
      chk($sformatf("v%0d_sdata", i), spi_data, vt[i].e_sdata);
      chk($sformatf("v%0d_tx", i), tx_count, vt[i].e_tx);
      chk($sformatf("v%0d_rx", i), rx_count, vt[i].e_rx);
      chk($sformatf("v%0d_ovld", i), out_valid, vt[i].e_ovld);
      if (vt[i].e_ovld) chk($sformatf("v%0d_odata", i), out_data, vt[i].e_od);
      chk($sformatf("v%0d_busy", i), busy, vt[i].e_busy);
      chk($sformatf("v%0d_iready", i), in_ready, vt[i].e_ir);
      chk($sformatf("v%0d_overrun", i), overrun, 0);
    end
    in_valid = 0; spi_arrived = 0; out_ready = 0;

    // Fill TX with master not ready; fifth word refused
    spi_ready = 0;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1; in_data = 8'h10 + 8'(i);
      step();
      chk("fill_tx_count", tx_count, (i < 4) ? i + 1 : 4);
      chk("fill_in_ready", in_ready, (i < 3) ? 1 : 0);
    end
    in_valid = 0;
    step();
    chk("fill_tx_hold", tx_count, 4);
    chk("fill_no_send", spi_send, 0);

    // Drain in order into RX (host not popping)
    spi_ready = 1;
    for (int i = 0; i < 4; i++) serve(8'h10 + 8'(i));
    chk("rx_full_count", rx_count, 4);
    chk("rx_full_valid", out_valid, 1);

    // RX full blocks the next issue
    in_valid = 1; in_data = 8'h20;
    step();
    in_valid = 0;
    chk("blk_tx_count", tx_count, 1);
    for (int i = 0; i < 6; i++) begin
      step();
      chk("blk_no_send", spi_send, 0);
    end
    chk("blk_rx_head", out_data, 8'hEF);
    out_ready = 1;
    step();
    out_ready = 0;
    chk("blk_rx_after_pop", rx_count, 3);
    serve(8'h20);
    exp_rx[0] = 8'hEE; exp_rx[1] = 8'hED; exp_rx[2] = 8'hEC; exp_rx[3] = 8'hDF;
    for (int i = 0; i < 4; i++) begin
      chk("drain_valid", out_valid, 1);
      chk("drain_data", out_data, exp_rx[i]);
      out_ready = 1;
      step();
      out_ready = 0;
    end
    chk("drain_empty", out_valid, 0);
    chk("drain_overrun", overrun, 0);

    // Arrived while idle
    spi_arrived = 1; spi_dataO = 8'h77;
    step();
    spi_arrived = 0;
    chk("ovr_set", overrun, 1);
    chk("ovr_rx_count", rx_count, 0);
    chk("ovr_busy", busy, 0);
    repeat (3) step();
    chk("ovr_sticky", overrun, 1);

    // Streaming 8 words with continuous RX pop, cycle-level count model
    tx_m = 0; rx_m = 0; ms = 0; ntx = 0; nrx = 0; nsent = 0; wcnt = -1; cyc = 0;
    spi_ready = 1; out_ready = 1;
    while (nrx < 8 && cyc < 400) begin
      in_valid = (ntx < 8); in_data = 8'(ntx);
      spi_arrived = (wcnt == 0); spi_dataO = spi_data;
      if (wcnt >= 0) wcnt--;
      if (rx_m != 0) begin
        chk("str_out_data", out_data, 8'(nrx));
        nrx++;
      end
      push   = in_valid && (tx_m != DEPTH);
      issue  = (ms == 0) && (tx_m != 0) && (rx_m != DEPTH) && spi_ready;
      rxpush = (ms == 2) && spi_arrived;
      rxpop  = (rx_m != 0);
      step();
      cyc++;
      if (push) ntx++;
      tx_m = tx_m + int'(push) - int'(issue);
      rx_m = rx_m + int'(rxpush) - int'(rxpop);
      if (ms == 0 && issue) ms = 1;
      else if (ms == 1) ms = 2;
      else if (ms == 2 && rxpush) ms = 0;
      chk("str_tx_count", tx_count, tx_m);
      chk("str_rx_count", rx_count, rx_m);
      chk("str_send", spi_send, (ms == 1) ? 1 : 0);
      chk("str_in_ready", in_ready, (tx_m != DEPTH) ? 1 : 0);
      if (ms == 1) begin
        chk("str_spi_data", spi_data, 8'(nsent));
        nsent++;
        wcnt = 2;
      end
    end
    chk("str_all_received", nrx, 8);
    in_valid = 0; spi_arrived = 0; out_ready = 0;
    step();

    // Async reset during WAIT with two words queued
    spi_ready = 1;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1; in_data = 8'hA0 + 8'(i);
      step();
    end
    in_valid = 0;
    chk("rw_busy", busy, 1);
    chk("rw_tx_count", tx_count, 2);
    chk("rw_send", spi_send, 0);
    repeat (2) step();
    chk("rw_still_busy", busy, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_spi_send", spi_send, 0);
    chk("ar_spi_data", spi_data, 0);
    chk("ar_busy", busy, 0);
    chk("ar_overrun", overrun, 0);
    chk("ar_tx_count", tx_count, 0);
    chk("ar_rx_count", rx_count, 0);
    chk("ar_in_ready", in_ready, 1);
    chk("ar_out_valid", out_valid, 0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    chk("post_rst_send", spi_send, 0);
    chk("post_rst_busy", busy, 0);
    spi_arrived = 1; spi_dataO = 8'h55;
    step();
    spi_arrived = 0;
    chk("post_rst_overrun", overrun, 1);
    chk("post_rst_rx", rx_count, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
